// File: rtl/register_op_sequencer_if.sv
// Command, response and downstream-register bundle for register_op_sequencer.
// The slave side is the sequencer; the master side is its environment.
interface register_op_sequencer_if #(
  parameter int W  = 4,
  parameter int CW = 4
);
  logic          CMD_VALID;
  logic          CMD_READY;
  logic [1:0]    CMD_OP;
  logic [CW-1:0] CMD_CNT;
  logic [W-1:0]  CMD_DATA;
  logic [W-1:0]  D;
  logic [1:0]    S;
  logic [W-1:0]  Y_IN;
  logic          RSP_VALID;
  logic          RSP_READY;
  logic [W-1:0]  RSP_DATA;
  logic          BUSY;

  modport master (
    output CMD_VALID,
    output CMD_OP,
    output CMD_CNT,
    output CMD_DATA,
    output Y_IN,
    output RSP_READY,
    input  CMD_READY,
    input  D,
    input  S,
    input  RSP_VALID,
    input  RSP_DATA,
    input  BUSY
  );

  modport slave (
    input  CMD_VALID,
    input  CMD_OP,
    input  CMD_CNT,
    input  CMD_DATA,
    input  Y_IN,
    input  RSP_READY,
    output CMD_READY,
    output D,
    output S,
    output RSP_VALID,
    output RSP_DATA,
    output BUSY
  );
endinterface

// File: rtl/register_op_sequencer.sv
// Drives a mode-select register with an op for CMD_CNT cycles, waits one
// settle cycle, then returns the register's output as a response.
module register_op_sequencer #(
  parameter int W  = 4,
  parameter int CW = 4
) (
  input  logic CLK,
  input  logic RESET_N,
  register_op_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  data_q, data_d;
  logic [W-1:0]  rsp_q, rsp_d;
  logic [1:0]    s_q, s_d;
  logic          accept;

  assign bus.CMD_READY = RESET_N && (state_q == IDLE);
  assign accept        = bus.CMD_VALID && bus.CMD_READY;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      data_q  <= '0;
      rsp_q   <= '0;
      s_q     <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (bus.CMD_CNT != '0) ? ISSUE : SETTLE;
        end
      end
      ISSUE: begin
        if (cnt_q == CW'(1)) begin
          state_d = SETTLE;
        end
      end
      SETTLE: state_d = RESP;
      RESP: begin
        if (bus.RSP_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // S is registered from the next state so it is glitch-free at the port.
  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    data_d = data_q;
    rsp_d  = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d  = bus.CMD_CNT;
          op_d   = bus.CMD_OP;
          data_d = bus.CMD_DATA;
        end
      end
      ISSUE:   cnt_d = cnt_q - CW'(1);
      SETTLE:  rsp_d = bus.Y_IN;
      default: ;
    endcase
    s_d = (state_d == ISSUE) ? op_d : 2'b00;
  end

  assign bus.S         = s_q;
  assign bus.D         = data_q;
  assign bus.RSP_DATA  = rsp_q;
  assign bus.RSP_VALID = (state_q == RESP);
  assign bus.BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_register_op_sequencer.sv
// Randomised scenario bench for register_op_sequencer with a cycle-level
// expectation derived from command count, op and the response handshake.
module tb_register_op_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  register_op_sequencer_if #(.W(4), .CW(4)) bus ();

  register_op_sequencer #(.W(4), .CW(4)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus.slave)
  );

  function automatic logic [8:0] obs();
    return {bus.CMD_READY, bus.BUSY, bus.S, bus.D, bus.RSP_VALID};
  endfunction

  // Full command: accept, N issue cycles, settle, bp stalled response cycles,
  // handshake. Busy-phase inputs are randomised to prove they are ignored.
  task automatic do_command(input logic [1:0] op, input logic [3:0] cnt,
                            input logic [3:0] data, input int bp,
                            input string tag);
    logic [3:0] y_exp;
    logic [8:0] exp_v;
    int n;
    n = int'(cnt);
    y_exp = 4'h0;
    n_cmp++;
    if (bus.CMD_READY !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_pre: got %b want 1", tag, bus.CMD_READY);
    end
    bus.CMD_VALID = 1'b1;
    bus.CMD_OP    = op;
    bus.CMD_CNT   = cnt;
    bus.CMD_DATA  = data;
    bus.RSP_READY = 1'($urandom);
    bus.Y_IN      = 4'($urandom);
    for (int e = 1; e <= n + 2; e++) begin
      if (e == n + 2) y_exp = bus.Y_IN;
      @(posedge clk);
      @(negedge clk);
      if (e <= n)          exp_v = {1'b0, 1'b1, op, data, 1'b0};
      else if (e == n + 1) exp_v = {1'b0, 1'b1, 2'b00, data, 1'b0};
      else                 exp_v = {1'b0, 1'b1, 2'b00, data, 1'b1};
      n_cmp++;
      if (obs() !== exp_v) begin
        n_err++;
        $display("FAIL %s cyc%0d {rdy,busy,S,D,rv}: got %b want %b",
                 tag, e, obs(), exp_v);
      end
      if (e == n + 2) begin
        n_cmp++;
        if (bus.RSP_DATA !== y_exp) begin
          n_err++;
          $display("FAIL %s rsp_data: got %h want %h", tag, bus.RSP_DATA, y_exp);
        end
      end
      bus.CMD_VALID = 1'($urandom);
      bus.CMD_OP    = 2'($urandom);
      bus.CMD_CNT   = 4'($urandom);
      bus.CMD_DATA  = 4'($urandom);
      bus.Y_IN      = 4'($urandom);
      bus.RSP_READY = (e < n + 2) ? 1'($urandom) : 1'b0;
    end
    for (int b = 0; b < bp; b++) begin
      @(posedge clk);
      @(negedge clk);
      exp_v = {1'b0, 1'b1, 2'b00, data, 1'b1};
      n_cmp++;
      if (obs() !== exp_v || bus.RSP_DATA !== y_exp) begin
        n_err++;
        $display("FAIL %s stall%0d: got %b/%h want %b/%h",
                 tag, b, obs(), bus.RSP_DATA, exp_v, y_exp);
      end
      bus.CMD_VALID = 1'b1;
      bus.CMD_OP    = 2'($urandom);
      bus.CMD_CNT   = 4'($urandom);
      bus.CMD_DATA  = 4'($urandom);
      bus.Y_IN      = 4'($urandom);
    end
    bus.RSP_READY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_v = {1'b1, 1'b0, 2'b00, data, 1'b0};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL %s post_hs: got %b want %b", tag, obs(), exp_v);
    end
    bus.RSP_READY = 1'b0;
    bus.CMD_VALID = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.CMD_VALID = 1'b0;
    bus.CMD_OP    = 2'b00;
    bus.CMD_CNT   = 4'h0;
    bus.CMD_DATA  = 4'h0;
    bus.Y_IN      = 4'h0;
    bus.RSP_READY = 1'b0;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== 9'b0 || bus.RSP_DATA !== 4'h0) begin
        n_err++;
        $display("FAIL reset_hold: got %b/%h want 0/0", obs(), bus.RSP_DATA);
      end
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== 9'b1_0_00_0000_0) begin
      n_err++;
      $display("FAIL reset_release: got %b want 100000000", obs());
    end
    @(negedge clk);
  endtask

  task automatic test_shift_right();
    do_command(2'b10, 4'd3, 4'b1101, 0, "shr3");
  endtask

  task automatic test_zero_count();
    do_command(2'b11, 4'd0, 4'($urandom), 1, "zero");
  endtask

  task automatic test_backpressure();
    do_command(2'b01, 4'd2, 4'($urandom), 4, "bp");
    do_command(2'b10, 4'd1, 4'($urandom), 0, "bp_next");
  endtask

  task automatic test_max_count();
    do_command(2'b01, 4'd15, 4'($urandom), 0, "max");
  endtask

  task automatic test_reset_mid_issue();
    n_cmp++;
    if (bus.CMD_READY !== 1'b1) begin
      n_err++;
      $display("FAIL mid_rst ready_pre: got %b want 1", bus.CMD_READY);
    end
    bus.CMD_VALID = 1'b1;
    bus.CMD_OP    = 2'b10;
    bus.CMD_CNT   = 4'd8;
    bus.CMD_DATA  = 4'b0110;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      @(negedge clk);
      bus.CMD_VALID = 1'b0;
      n_cmp++;
      if (obs() !== {1'b0, 1'b1, 2'b10, 4'b0110, 1'b0}) begin
        n_err++;
        $display("FAIL mid_rst issue%0d: got %b want 0110_0110_0", e, obs());
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== 9'b0 || bus.RSP_DATA !== 4'h0) begin
      n_err++;
      $display("FAIL mid_rst async: got %b/%h want 0/0", obs(), bus.RSP_DATA);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== 9'b1_0_00_0000_0) begin
      n_err++;
      $display("FAIL mid_rst release: got %b want 100000000", obs());
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.RSP_READY = 1'($urandom);
      n_cmp++;
      if (bus.RSP_VALID !== 1'b0 || bus.BUSY !== 1'b0) begin
        n_err++;
        $display("FAIL mid_rst quiet%0d: rv/busy got %b%b want 00",
                 i, bus.RSP_VALID, bus.BUSY);
      end
    end
    bus.RSP_READY = 1'b0;
    do_command(2'b10, 4'd8, 4'($urandom), 1, "after_rst");
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      do_command(2'($urandom), 4'($urandom), 4'($urandom),
                 int'($urandom_range(0, 3)), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_shift_right();
    test_zero_count();
    test_backpressure();
    test_max_count();
    test_reset_mid_issue();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
